// File: rtl/expand_a.sv
// expand_a: ML-DSA ExpandA, rejection-samples a SHAKE128 stream into the K x L matrix A in coefficient RAM.
// Optional EXPANDA_STATE_CACHE_EN absorbs rho once and restores the cached sponge state per polynomial.
module expand_a #(
  parameter int K = 8,
  parameter int L = 7,
  parameter int BASE_OFFSET = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] rho,
  output logic        done,
  output logic        we_matA,
  output logic [11:0] addr_matA,
  output logic [95:0] din_matA,
  output logic        absorb_next_poly,
  output logic [63:0] shake_data_in,
  output logic        in_valid,
  output logic        in_last,
  output logic [6:0]  last_len,
  output logic        cache_rd,
  output logic        cache_wr,
  output logic        out_ready,
  input  logic [63:0] shake_data_out,
  input  logic        out_valid,
  input  logic        in_ready
);
  typedef enum logic [3:0] {IDLE, LOAD, CLEAR, CRD, ABSORB, CWR, SQUEEZE, NEXT, DONE} state_t;
  state_t state, nxt;
  logic [63:0] rho_r [4];
  logic [2:0]  w;
  logic [7:0]  k, l, n;
  logic [5:0]  p;
  logic [3:0]  cnt;
  logic [79:0] bbuf;
  logic [95:0] pack;
  logic [22:0] t;
  logic        proc, ok;
`ifdef EXPANDA_STATE_CACHE_EN
  logic        pre;
`endif
  // bytes b0,b1,b2 with the top bit of b2 masked form the low 23 bits of the buffer
  assign t = bbuf[22:0];
  assign proc = state == SQUEEZE && cnt >= 4'd3;
  assign ok = proc && t < 23'd8380417;
  assign absorb_next_poly = state == CLEAR;
  assign in_valid = state == ABSORB;
  assign in_last = in_valid && w == 3'd4;
  assign last_len = in_last ? 7'd16 : 7'd0;
  assign shake_data_in = !in_valid ? 64'd0 : w == 3'd4 ? {48'd0, k, l} : rho_r[w[1:0]];
  assign out_ready = state == SQUEEZE && cnt <= 4'd2;
`ifdef EXPANDA_STATE_CACHE_EN
  assign cache_rd = state == CRD;
  assign cache_wr = state == CWR;
`else
  assign cache_rd = 1'b0;
  assign cache_wr = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = w == 3'd3 ? CLEAR : LOAD;
`ifdef EXPANDA_STATE_CACHE_EN
      CLEAR:   nxt = pre ? ABSORB : CRD;
      CRD:     nxt = ABSORB;
      ABSORB:  nxt = !in_ready ? ABSORB : (pre && w == 3'd3) ? CWR : w == 3'd4 ? SQUEEZE : ABSORB;
      CWR:     nxt = CLEAR;
`else
      CLEAR:   nxt = ABSORB;
      ABSORB:  nxt = (in_ready && w == 3'd4) ? SQUEEZE : ABSORB;
`endif
      SQUEEZE: nxt = (ok && n == 8'd255) ? NEXT : SQUEEZE;
      NEXT:    nxt = p == 6'(K * L - 1) ? DONE : CLEAR;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      done <= 1'b0;
      we_matA <= 1'b0;
      addr_matA <= '0;
      din_matA <= '0;
      rho_r <= '{default: '0};
      w <= '0;
      k <= '0;
      l <= '0;
      n <= '0;
      p <= '0;
      cnt <= '0;
      bbuf <= '0;
      pack <= '0;
`ifdef EXPANDA_STATE_CACHE_EN
      pre <= 1'b0;
`endif
    end else begin
      state <= nxt;
      we_matA <= 1'b0;
      case (state)
        IDLE: if (start) begin
          done <= 1'b0;
          w <= '0;
          k <= '0;
          l <= '0;
          p <= '0;
        end
        LOAD: begin
          rho_r[w[1:0]] <= rho;
          w <= w + 3'd1;
`ifdef EXPANDA_STATE_CACHE_EN
          pre <= 1'b1;
`endif
        end
        CLEAR: begin
          cnt <= '0;
          bbuf <= '0;
          n <= '0;
`ifdef EXPANDA_STATE_CACHE_EN
          w <= pre ? 3'd0 : 3'd4;
`else
          w <= 3'd0;
`endif
        end
        ABSORB: if (in_ready) w <= w + 3'd1;
`ifdef EXPANDA_STATE_CACHE_EN
        CWR: pre <= 1'b0;
`endif
        SQUEEZE: begin
          if (proc) begin
            bbuf <= bbuf >> 24;
            cnt <= cnt - 4'd3;
            if (ok) begin
              n <= n + 8'd1;
              pack[n[1:0] * 24 +: 24] <= {1'b0, t};
              if (n[1:0] == 2'd3) begin
                we_matA <= 1'b1;
                addr_matA <= 12'(BASE_OFFSET) + {p, 6'd0} + {6'd0, n[7:2]};
                din_matA <= {1'b0, t, pack[71:0]};
              end
            end
          end else if (out_valid && out_ready) begin
            bbuf <= bbuf | (80'(shake_data_out) << {cnt, 3'b0});
            cnt <= cnt + 4'd8;
          end
        end
        NEXT: begin
          p <= p + 6'd1;
          l <= l == 8'(L - 1) ? 8'd0 : l + 8'd1;
          k <= l == 8'(L - 1) ? k + 8'd1 : k;
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_expand_a.sv
// tb_expand_a: directed bench for expand_a with a byte-pattern sponge stub.
module tb_expand_a;
  localparam int K = 8;
  localparam int L = 7;
  localparam int BASE = 0;
  localparam int NW = K * L * 64;
  localparam logic [63:0] RHO = 64'h1234567890abcdef;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [63:0] rho = '0;
  logic done, we_matA, absorb_next_poly, in_valid, in_last, cache_rd, cache_wr, out_ready;
  logic [11:0] addr_matA;
  logic [95:0] din_matA;
  logic [63:0] shake_data_in, shake_data_out;
  logic [6:0] last_len;
  logic out_valid, in_ready;
  logic stall = 1'b0, tog = 1'b0, pat = 1'b0;
  int widx = 0;
  int compared = 0, mismatched = 0;
  logic [186:0] outs;
  logic [95:0] exp_b [3] = '{
    {24'h000000, 24'h02FFFF, 24'h7F0000, 24'h000002},
    {24'h7F0000, 24'h000002, 24'h000000, 24'h0002FF},
    {24'h000000, 24'h0002FF, 24'h000000, 24'h02FFFF}};

  expand_a #(.K(K), .L(L), .BASE_OFFSET(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .rho(rho), .done(done),
    .we_matA(we_matA), .addr_matA(addr_matA), .din_matA(din_matA),
    .absorb_next_poly(absorb_next_poly), .shake_data_in(shake_data_in),
    .in_valid(in_valid), .in_last(in_last), .last_len(last_len),
    .cache_rd(cache_rd), .cache_wr(cache_wr), .out_ready(out_ready),
    .shake_data_out(shake_data_out), .out_valid(out_valid), .in_ready(in_ready));

  always #5 clk = ~clk;

  function automatic logic [63:0] word_a(input int i);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = ((8 * i + j) % 3 == 0) ? 8'h01 : 8'h00;
    return v;
  endfunction

  function automatic logic [71:0] exp_abs(input int t);
    int pi;
`ifdef EXPANDA_STATE_CACHE_EN
    if (t < 4) return {1'b0, 7'd0, RHO + 64'(t)};
    pi = t - 4;
`else
    if (t % 5 < 4) return {1'b0, 7'd0, RHO + 64'(t % 5)};
    pi = t / 5;
`endif
    return {1'b1, 7'd16, 48'd0, 8'(pi / L), 8'(pi % L)};
  endfunction

  assign in_ready = stall ? tog : 1'b1;
  assign out_valid = stall ? tog : 1'b1;
  assign shake_data_out = pat ? 64'h00000000_02FFFFFF : word_a(widx);
  assign outs = {done, we_matA, addr_matA, din_matA, absorb_next_poly, shake_data_in,
                 in_valid, in_last, last_len, cache_rd, cache_wr, out_ready};

  // sponge stub: the squeeze stream restarts with every polynomial
  always @(posedge clk) begin
    tog <= ~tog;
    if (absorb_next_poly) widx <= 0;
    else if (out_valid && out_ready) widx <= widx + 1;
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rho = RHO + 64'(i);
      @(negedge clk);
    end
    rho = '0;
  endtask

  task automatic run_a();
    int nwr = 0, t = 0, npol = 0, nov = 0, crd = 0, cwr = 0, c, t8;
    logic [71:0] w8 = '0;
`ifdef EXPANDA_STATE_CACHE_EN
    t8 = 4 + 8;
`else
    t8 = 5 * 8 + 4;
`endif
    kick();
    for (c = 0; c < 45000 && done !== 1'b1; c++) begin
      if (c == 300) start = 1'b1;
      if (c == 301) start = 1'b0;
      if (we_matA) begin
        chk("a_addr", addr_matA, 192'(BASE + nwr));
        chk("a_din", din_matA, {4{24'h000001}});
        nwr++;
      end
      if (in_valid && in_ready) begin
        chk("absorb_word", {in_last, last_len, shake_data_in}, exp_abs(t));
        if (t == t8) w8 = {in_last, last_len, shake_data_in};
        t++;
      end
      if (absorb_next_poly) npol++;
      if (absorb_next_poly && in_valid) nov++;
      crd += int'(cache_rd);
      cwr += int'(cache_wr);
      @(negedge clk);
    end
    chk("a_timeout", c < 45000, 1);
    chk("a_writes", nwr, NW);
    chk("p8_kl_word", w8, {1'b1, 7'd16, 64'h0101});
    chk("clear_overlap", nov, 0);
`ifdef EXPANDA_STATE_CACHE_EN
    chk("clear_pulses", npol, K * L + 1);
    chk("transfers", t, 4 + K * L);
    chk("cache_wr", cwr, 1);
    chk("cache_rd", crd, K * L);
`else
    chk("clear_pulses", npol, K * L);
    chk("transfers", t, 5 * K * L);
    chk("cache_wr", cwr, 0);
    chk("cache_rd", crd, 0);
`endif
    repeat (3) @(negedge clk);
    chk("done_hold", {done, we_matA, in_valid, out_ready}, 4'b1000);
  endtask

  initial begin
    int nb = 0, c;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs, 0);
    run_a();
    pat = 1'b1;
    kick();
    for (c = 0; c < 2000 && nb < 3; c++) begin
      if (we_matA) begin
        chk("b_addr", addr_matA, 192'(BASE + nb));
        chk("b_din", din_matA, exp_b[nb]);
        nb++;
      end
      if (nb < 3) @(negedge clk);
    end
    chk("b_writes", nb, 3);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outs", outs, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", outs, 0);
    pat = 1'b0;
    stall = 1'b1;
    run_a();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/expand_a.md
# expand_a

ML-DSA ExpandA engine: takes the 256-bit public seed rho and fills the K×L matrix A with uniformly sampled coefficients mod q = 8380417. It drives an external SHAKE128 sponge (capacity 256, 64-bit data paths), rejection-samples its squeeze stream, and writes packed coefficients into the NTT-domain coefficient RAM through a single write port. It sits in the key-generation, sign and verify datapaths in front of the NTT/matrix-multiply stage.

## Interface
- K, 8, matrix rows (ML-DSA-87).
- L, 7, matrix columns.
- BASE_OFFSET, 0, first RAM word of A; requires BASE_OFFSET + K·L·64 ≤ 4096.

Clock is `clk`; reset is `rst`, synchronous, active-low.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; ignored unless idle.
- rho  in  64  seed word; 4 consecutive words, little-endian bytes.
- done  out  1  high from completion until next accepted start.
- we_matA  out  1  RAM write strobe.
- addr_matA  out  12  RAM word address.
- din_matA  out  96  four 24-bit coefficients.
- absorb_next_poly  out  1  one-cycle sponge clear before each polynomial.
- shake_data_in  out  64  absorb word.
- in_valid  out  1  absorb word valid.
- in_last  out  1  final absorb word.
- last_len  out  7  valid bits of final word.
- cache_rd  out  1  restore cached sponge state.
- cache_wr  out  1  save sponge state to cache.
- out_ready  out  1  ready for squeeze word.
- shake_data_out  in  64  squeeze word.
- out_valid  in  1  squeeze word valid.
- in_ready  in  1  sponge accepts absorb word.

## Operation
- States: IDLE, LOAD (4 cycles), CLEAR, ABSORB, SQUEEZE, NEXT, DONE.
- IDLE: start=1 → LOAD, done←0. The cycles after start carry rho words 0..3, captured into a 4×64 register.
- Polynomials are produced in order p = k·L + l, with k outer (0..K-1) and l inner (0..L-1).
- Per polynomial: CLEAR pulses absorb_next_poly for one cycle. ABSORB sends rho words 0..3 with in_last=0, then the word {48'b0, k[7:0], l[7:0]} (byte0 = l, byte1 = k) with in_last=1 and last_len=16.
- Absorb transfers occur only when in_valid && in_ready. in_valid is held with stable data until the transfer.
- SQUEEZE: a squeeze word is accepted when out_valid && out_ready. Its 8 bytes (byte0 = bits[7:0]) are appended to a byte buffer of at least 10 bytes.
- out_ready=1 only while the buffer holds ≤2 bytes and the polynomial is incomplete.
- Every 3 buffered bytes b0,b1,b2 form t = b0 + 256·b1 + 65536·(b2 & 0x7F). If t < 8380417 the coefficient is accepted, otherwise it is discarded. One triple is processed per cycle.
- Accepted coefficient n (0..255) goes to slot n%4 at bits [24·(n%4) +: 24], zero-extended.
- When slot 3 fills, the block issues we_matA=1, addr = BASE_OFFSET + p·64 + n/4, din = the packed word.
- After coefficient 255 is written, leftover buffered bytes are dropped and the state moves to NEXT. NEXT advances (k,l) and returns to CLEAR, or goes to DONE after p = K·L−1.
- DONE: done=1, return to IDLE. done stays high until the next start.
- start while busy is ignored.
- Reset at any time: go to IDLE; all outputs 0; buffer, counters and the done flag cleared.

## Timing
- Reset values: all outputs 0.
- we_matA is a single-cycle pulse; addr and din are valid in that same cycle.
- absorb_next_poly is exactly one cycle, never asserted together with in_valid.
- Triple processing latency: accepted coefficient is visible in a RAM write no later than 2 cycles after its last byte is buffered.
- Total latency is data-dependent (rejection). Minimum per polynomial: 5 absorb transfers + 96 squeeze words.
- Rate boundary (21 words/block) is transparent; the sponge stalls out_valid.

## Configuration
- EXPANDA_STATE_CACHE_EN defined:
  - After LOAD, the sponge is cleared and rho words 0..3 are absorbed once; cache_wr pulses one cycle to save that state.
  - Each polynomial then performs CLEAR, cache_rd for one cycle, and absorbs only the {k,l} word.
- Undefined: cache_rd and cache_wr are tied to 0, and all 5 words are absorbed per polynomial.

## Test plan
- Reset mid-SQUEEZE (rst=0 for 1 cycle) → all outputs 0, IDLE; a new start completes normally.
- Sponge stub returns bytes 01 00 00 repeated → every coefficient = 1; each word 0x000001_000001_000001_000001.
  - Addresses BASE_OFFSET..+3583 are written once each, in increasing order; done rises.
- Stub word bytes FF FF FF 02 00 00 00 00 → 0x7FFFFF rejected, 2 accepted, trailing 0x000000 accepted as 0. Verify the slot order.
- Stub stalls: in_ready/out_valid toggling every other cycle → RAM contents identical to the no-stall run.
- Real sponge, rho = 4×0x1234567890abcdef, K=8, L=7 → all 14336 coefficients < 8380417 and match the golden Python ExpandA.
  - Absorb word for p=8 is 0x0101 (k=1, l=1) with last_len=16.
- start pulsed during busy → ignored; with EXPANDA_STATE_CACHE_EN, exactly 1 cache_wr and 56 cache_rd pulses.
